// File: rtl/prob_pulse_encoder_pkg.sv
// Shared definitions for the probability pulse encoder: Q15 constants and FSM states.
package prob_pulse_encoder_pkg;

  localparam int DW      = 17;
  localparam int FRAC    = 15;
  localparam int Q15_ONE = 32768;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    GAP,
    PULSE,
    TAIL
  } state_e;

endpackage

// File: rtl/prob_pulse_encoder_cmag2.sv
// Combinational |a|^2 of a signed Q2.15 complex sample, clamped to 1.0 with a saturation flag.
module cmag2
  import prob_pulse_encoder_pkg::*;
#(
  parameter int AW = DW
) (
  input  logic signed [AW-1:0] re,
  input  logic signed [AW-1:0] im,
  output logic        [AW+1:0] p,
  output logic                 sat
);

  localparam logic [AW+1:0] ONE = (AW+2)'(Q15_ONE);

  logic signed [2*AW-1:0] re_sq;
  logic signed [2*AW-1:0] im_sq;
  logic        [AW+1:0]   re_term;
  logic        [AW+1:0]   im_term;
  logic        [AW+1:0]   sum;

  // Each square is rescaled back to Q15 and truncated, then the sum is clamped at 1.0
  always_comb begin
    re_sq   = re * re;
    im_sq   = im * im;
    re_term = (AW+2)'(re_sq >>> FRAC);
    im_term = (AW+2)'(im_sq >>> FRAC);
    sum     = re_term + im_term;
    sat     = (sum > ONE);
    p       = sat ? ONE : sum;
  end

endmodule

// File: rtl/prob_pulse_encoder.sv
// Loads a frame of complex amplitudes, converts each to a pulse width, and plays a gap/pulse train on sq.
module prob_pulse_encoder #(
  parameter int          NSTATES    = 8,
  parameter int          DW         = prob_pulse_encoder_pkg::DW,
  parameter int          CW         = 32,
  parameter int unsigned GAP_CYC    = 5500000,
  parameter int unsigned PULSE_FULL = 2500000,
  parameter int unsigned TAIL_CYC   = 11000000,
  localparam int         IW         = $clog2(NSTATES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 amp_valid,
  output logic                 amp_ready,
  input  logic signed [DW-1:0] amp_re,
  input  logic signed [DW-1:0] amp_im,
  input  logic                 repeat_en,
  input  logic                 abort,
  output logic                 sq,
  output logic                 busy,
  output logic [IW-1:0]        cur_idx,
  output logic                 frame_done,
  output logic                 sat
);

  import prob_pulse_encoder_pkg::*;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NSTATES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL_CYC - 1);
  localparam int            PW        = CW + DW + 2;

  state_e          state;
  state_e          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_next;
  logic [IW-1:0]   load_idx;
  logic [IW-1:0]   load_next;
  logic [CW-1:0]   wbuf [NSTATES];
  logic [CW-1:0]   cur_w;
  logic            accept;
  logic            done_now;
  logic [DW+1:0]   p_comb;
  logic            sat_comb;
  logic [DW+1:0]   p_reg;
  logic [IW-1:0]   p_idx;
  logic            p_valid;
  logic [PW-1:0]   prod;
  logic [CW-1:0]   w_new;

  cmag2 #(
    .AW  (DW)
  ) u_cmag2 (
    .re  (amp_re),
    .im  (amp_im),
    .p   (p_comb),
    .sat (sat_comb)
  );

  assign accept     = amp_valid & amp_ready & ~abort;
  assign cur_w      = wbuf[idx];
  assign cur_idx    = idx;
  assign frame_done = done_now;

  // Width scaling for the beat captured on the previous edge
  always_comb begin
    prod  = PW'(p_reg) * PW'(PULSE_FULL);
    w_new = CW'(prod >> FRAC);
  end

  // First pipeline stage: hold the clamped probability and its destination index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_reg   <= '0;
      p_idx   <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_reg <= p_comb;
        p_idx <= load_idx;
      end
    end
  end

  // Width buffer write, one edge after the handshake; contents need no reset
  always_ff @(posedge clk) begin
    if (p_valid) begin
      wbuf[p_idx] <= w_new;
    end
  end

  // Saturation flag restarts on the first beat of each frame and accumulates over the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= 1'b0;
    end else if (accept) begin
      sat <= (state == IDLE) ? sat_comb : (sat | sat_comb);
    end
  end

  // Next-state logic: loading, then walking the gap/pulse sequence and the tail
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    idx_next   = idx;
    load_next  = load_idx;
    done_now   = 1'b0;
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
      load_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next = '0;
          if (accept) begin
            state_next = LOAD;
            load_next  = IW'(1);
          end
        end
        LOAD: begin
          cnt_next = '0;
          if (accept) begin
            if (load_idx == LAST_IDX) begin
              state_next = WAIT;
              load_next  = '0;
            end else begin
              load_next = load_idx + IW'(1);
            end
          end
        end
        WAIT: begin
          state_next = GAP;
          cnt_next   = '0;
          idx_next   = '0;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_next = '0;
            if (cur_w != '0) begin
              state_next = PULSE;
            end else if (idx == LAST_IDX) begin
              state_next = TAIL;
            end else begin
              idx_next = idx + IW'(1);
            end
          end
        end
        PULSE: begin
          if (cnt == cur_w - CW'(1)) begin
            cnt_next = '0;
            if (idx == LAST_IDX) begin
              state_next = TAIL;
            end else begin
              state_next = GAP;
              idx_next   = idx + IW'(1);
            end
          end
        end
        TAIL: begin
          if (cnt == TAIL_LAST) begin
            done_now   = 1'b1;
            cnt_next   = '0;
            idx_next   = '0;
            state_next = repeat_en ? GAP : IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
          idx_next   = '0;
          load_next  = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs; sq/busy/ready follow the next state so they never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      load_idx  <= '0;
      sq        <= 1'b0;
      busy      <= 1'b0;
      amp_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      load_idx  <= load_next;
      sq        <= (state_next == PULSE);
      busy      <= (state_next != IDLE) && (state_next != LOAD);
      amp_ready <= (state_next == IDLE) || (state_next == LOAD);
    end
  end

endmodule

// File: tb/tb_prob_pulse_encoder.sv
// Testbench for prob_pulse_encoder: frames are checked cycle by cycle against a pulse-train model.
module tb_prob_pulse_encoder;

  localparam int NS = 4;
  localparam int GP = 4;
  localparam int PF = 64;
  localparam int TL = 8;

  logic               clk;
  logic               rst_n;
  logic               amp_valid;
  logic               amp_ready;
  logic signed [16:0] amp_re;
  logic signed [16:0] amp_im;
  logic               repeat_en;
  logic               abort;
  logic               sq;
  logic               busy;
  logic [1:0]         cur_idx;
  logic               frame_done;
  logic               sat;

  int assertCount = 0;
  int failCount   = 0;

  int fre [NS];
  int fim [NS];
  int expW [NS];
  bit expSat;

  prob_pulse_encoder #(
    .NSTATES    (NS),
    .DW         (17),
    .CW         (32),
    .GAP_CYC    (GP),
    .PULSE_FULL (PF),
    .TAIL_CYC   (TL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .amp_valid  (amp_valid),
    .amp_ready  (amp_ready),
    .amp_re     (amp_re),
    .amp_im     (amp_im),
    .repeat_en  (repeat_en),
    .abort      (abort),
    .sq         (sq),
    .busy       (busy),
    .cur_idx    (cur_idx),
    .frame_done (frame_done),
    .sat        (sat)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference widths: |a|^2 in Q15 with floor division, clamp at 1.0, scale to PF
  task automatic build_model();
    longint p;
    expSat = 1'b0;
    for (int i = 0; i < NS; i++) begin
      p = (longint'(fre[i]) * longint'(fre[i])) / 32768 + (longint'(fim[i]) * longint'(fim[i])) / 32768;
      if (p > 32768) begin
        p = 32768;
        expSat = 1'b1;
      end
      expW[i] = int'((p * PF) / 32768);
    end
  endtask

  task automatic set_frame(input int r0, input int i0, input int r1, input int i1,
                           input int r2, input int i2, input int r3, input int i3);
    fre[0] = r0; fim[0] = i0;
    fre[1] = r1; fim[1] = i1;
    fre[2] = r2; fim[2] = i2;
    fre[3] = r3; fim[3] = i3;
    build_model();
  endtask

  task automatic random_frame();
    for (int i = 0; i < NS; i++) begin
      fre[i] = int'($urandom_range(65535, 0)) - 32768;
      fim[i] = int'($urandom_range(65535, 0)) - 32768;
    end
    build_model();
  endtask

  // Offers nBeats beats with random idle gaps; every wait for ready is bounded
  task automatic load_frame(input int gapMax, input int nBeats);
    int waitCyc;
    for (int i = 0; i < nBeats; i++) begin
      if (gapMax > 0) begin
        repeat ($urandom_range(gapMax, 0)) begin
          amp_valid = 1'b0;
          amp_re    = 17'($urandom);
          amp_im    = 17'($urandom);
          @(negedge clk);
        end
      end
      amp_valid = 1'b1;
      amp_re    = 17'(fre[i]);
      amp_im    = 17'(fim[i]);
      waitCyc   = 0;
      while (amp_ready !== 1'b1 && waitCyc < 50) begin
        @(negedge clk);
        waitCyc++;
      end
      assertCount++;
      if (amp_ready !== 1'b1) begin
        $display("[TB] FAIL load_ready beat %0d: amp_ready=%b required 1", i, amp_ready);
        failCount++;
      end
      @(negedge clk);
    end
    amp_valid = 1'b0;
  endtask

  // Called in the WAIT cycle right after the last beat is taken
  task automatic check_wait(input string name);
    assertCount++;
    if (busy !== 1'b1 || amp_ready !== 1'b0 || sq !== 1'b0 || sat !== expSat) begin
      $display("[TB] FAIL %s_wait: busy=%b ready=%b sq=%b sat=%b required busy=1 ready=0 sq=0 sat=%b",
               name, busy, amp_ready, sq, sat, expSat);
      failCount++;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    assertCount++;
    if (busy !== 1'b0 || amp_ready !== 1'b1 || sq !== 1'b0) begin
      $display("[TB] FAIL %s_idle: busy=%b ready=%b sq=%b required busy=0 ready=1 sq=0",
               name, busy, amp_ready, sq);
      failCount++;
    end
  endtask

  // Walks one frame period; the next negedge must be the first gap cycle of index 0
  task automatic check_period(input string name, input int dropAt);
    bit qsq [$];
    int qidx [$];
    int bad, firstBad, fdCount, fdAt;
    logic badSq;
    logic [1:0] badIdx;
    for (int i = 0; i < NS; i++) begin
      repeat (GP) begin qsq.push_back(1'b0); qidx.push_back(i); end
      repeat (expW[i]) begin qsq.push_back(1'b1); qidx.push_back(i); end
    end
    repeat (TL) begin qsq.push_back(1'b0); qidx.push_back(-1); end
    bad = 0; firstBad = -1; fdCount = 0; fdAt = -1;
    badSq = 1'b0; badIdx = '0;
    for (int k = 0; k < qsq.size(); k++) begin
      @(negedge clk);
      if (sq !== qsq[k] || (qidx[k] >= 0 && cur_idx !== 2'(qidx[k]))) begin
        if (bad == 0) begin
          firstBad = k; badSq = sq; badIdx = cur_idx;
        end
        bad++;
      end
      if (frame_done !== 1'b0) begin
        fdCount++;
        fdAt = k + 1;
      end
      if (k == dropAt) repeat_en = 1'b0;
    end
    assertCount++;
    if (bad !== 0) begin
      $display("[TB] FAIL %s_trace: %0d bad cycles, first at cycle %0d sq=%b idx=%0d required sq=%b idx=%0d",
               name, bad, firstBad + 1, badSq, badIdx, qsq[firstBad], qidx[firstBad]);
      failCount++;
    end
    assertCount++;
    if (fdCount !== 1 || fdAt !== qsq.size()) begin
      $display("[TB] FAIL %s_frame_done: count=%0d at cycle %0d required count=1 at cycle %0d",
               name, fdCount, fdAt, qsq.size());
      failCount++;
    end
  endtask

  task automatic run_frame(input string name, input int gapMax);
    load_frame(gapMax, NS);
    check_wait(name);
    check_period(name, -1);
    check_idle(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++;
    if (sq !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || sat !== 1'b0 ||
        cur_idx !== 2'd0 || amp_ready !== 1'b0) begin
      $display("[TB] FAIL reset_state: sq=%b busy=%b fd=%b sat=%b idx=%0d ready=%b required all 0",
               sq, busy, frame_done, sat, cur_idx, amp_ready);
      failCount++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    repeat_en = 1'b0;
    set_frame(23170, 0, -23170, 0, 0, 0, 0, 0);
    run_frame("basic", 0);
  endtask

  task automatic test_widths();
    set_frame(16384, 16384, 32768, 0, 0, -32768, 0, 0);
    run_frame("widths", 0);
  endtask

  task automatic test_saturation();
    set_frame(32768, 32768, 1000, 2000, -5000, 300, 0, 0);
    run_frame("sat", 0);
    set_frame(8000, -9000, 0, 12000, 20000, 0, -3000, 3000);
    run_frame("sat_clear", 1);
  endtask

  task automatic test_repeat();
    random_frame();
    repeat_en = 1'b1;
    load_frame(0, NS);
    check_wait("repeat");
    check_period("repeat_p1", -1);
    check_period("repeat_p2", 20);
    check_idle("repeat");
  endtask

  task automatic test_abort_load();
    random_frame();
    load_frame(0, 2);
    abort     = 1'b1;
    amp_valid = 1'b1;
    amp_re    = 17'(12345);
    amp_im    = 17'(-2222);
    @(negedge clk);
    abort     = 1'b0;
    amp_valid = 1'b0;
    assertCount++;
    if (busy !== 1'b0 || amp_ready !== 1'b1 || sq !== 1'b0) begin
      $display("[TB] FAIL abort_load: busy=%b ready=%b sq=%b required busy=0 ready=1 sq=0",
               busy, amp_ready, sq);
      failCount++;
    end
    set_frame(20000, 5000, 0, 0, -30000, 1000, 10000, -10000);
    run_frame("after_abort", 0);
  endtask

  task automatic test_abort_pulse();
    int fdSeen, sqSeen;
    set_frame(32768, 0, 100, 0, 0, 0, 0, 0);
    load_frame(0, NS);
    check_wait("abort_pulse");
    repeat (GP + 5) @(negedge clk);
    assertCount++;
    if (sq !== 1'b1) begin
      $display("[TB] FAIL abort_pre_pulse: sq=%b required 1", sq);
      failCount++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    assertCount++;
    if (sq !== 1'b0 || busy !== 1'b0 || amp_ready !== 1'b1) begin
      $display("[TB] FAIL abort_pulse: sq=%b busy=%b ready=%b required sq=0 busy=0 ready=1",
               sq, busy, amp_ready);
      failCount++;
    end
    fdSeen = 0; sqSeen = 0;
    repeat (150) begin
      @(negedge clk);
      if (frame_done !== 1'b0) fdSeen++;
      if (sq !== 1'b0) sqSeen++;
    end
    assertCount++;
    if (fdSeen !== 0 || sqSeen !== 0) begin
      $display("[TB] FAIL abort_quiet: frame_done cycles=%0d sq cycles=%0d required 0 and 0", fdSeen, sqSeen);
      failCount++;
    end
  endtask

  task automatic test_random_reset();
    int waitCyc;
    for (int f = 0; f < 3; f++) begin
      random_frame();
      run_frame($sformatf("rand%0d", f), 3);
    end
    random_frame();
    fre[1] = 30000;
    build_model();
    load_frame(3, NS);
    check_wait("rst_mid");
    waitCyc = 0;
    while (sq !== 1'b1 && waitCyc < 300) begin
      @(negedge clk);
      waitCyc++;
    end
    assertCount++;
    if (sq !== 1'b1) begin
      $display("[TB] FAIL rst_mid_pulse_seen: sq=%b required 1", sq);
      failCount++;
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    assertCount++;
    if (sq !== 1'b0 || busy !== 1'b0 || cur_idx !== 2'd0 || frame_done !== 1'b0 || amp_ready !== 1'b0) begin
      $display("[TB] FAIL async_reset: sq=%b busy=%b idx=%0d fd=%b ready=%b required all 0",
               sq, busy, cur_idx, frame_done, amp_ready);
      failCount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat_en = 1'b0;
    set_frame(23170, 0, -23170, 0, 0, 0, 0, 0);
    run_frame("post_reset", 2);
  endtask

  // Test sequence
  initial begin
    rst_n     = 1'b0;
    amp_valid = 1'b0;
    amp_re    = '0;
    amp_im    = '0;
    repeat_en = 1'b0;
    abort     = 1'b0;
    test_reset();
    test_basic();
    test_widths();
    test_saturation();
    test_repeat();
    test_abort_load();
    test_abort_pulse();
    test_random_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
